// File: rtl/shift_deserializer.sv
// shift_deserializer: serial-in/parallel-out receiver.
//   Collects qualified serial bits into a WIDTH-bit word (MSB-first or LSB-first, chosen
//   by dir on the first bit of each frame) and presents completed words on a double-buffered
//   valid/ready output. Words completed while the output is held are dropped and flagged by
//   a sticky overrun bit.
//
// Optional feature macro: PARITY_CHECK_EN
//   Defined  : frame = WIDTH data bits + 1 even-parity bit; parity_err reports a mismatch.
//   Undefined: frame = WIDTH data bits; parity_err is constant 0.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous reset, active low
//   clear      in   synchronous flush (keeps out data), priority over everything else
//   bit_valid  in   bit_in is sampled this cycle
//   bit_in     in   serial data bit
//   dir        in   0 = MSB first (shift left), 1 = LSB first (shift right)
//   out        out  assembled word (output buffer)
//   out_valid  out  out holds an unconsumed word
//   out_ready  in   consumer accepts out when out_valid & out_ready
//   busy       out  a frame is partially collected
//   bit_count  out  bits collected in the current frame
//   overrun    out  sticky: a completed word was dropped
//   parity_err out  parity mismatch on the current out word
module shift_deserializer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             dir,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] bit_count,
  output logic             overrun,
  output logic             parity_err
);

  localparam logic [CNT_W-1:0] LastData = CNT_W'(WIDTH - 1);

`ifdef PARITY_CHECK_EN
  typedef enum logic [1:0] {StIdle, StShift, StParity} state_e;
`else
  typedef enum logic [0:0] {StIdle, StShift} state_e;
`endif

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dir_q, dir_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               out_valid_q, out_valid_d;
  logic               overrun_q, overrun_d;
  logic               dir_eff;
  logic [WIDTH-1:0]   shifted;
  logic [WIDTH-1:0]   word;
  logic               done;
`ifdef PARITY_CHECK_EN
  logic               par_calc;
  logic               parity_err_q, parity_err_d;
`endif

  // The first bit of a frame uses the live dir; later bits use the latched copy.
  assign dir_eff = (state_q == StIdle) ? dir : dir_q;
  assign shifted = dir_eff ? {bit_in, shift_q[WIDTH-1:1]} : {shift_q[WIDTH-2:0], bit_in};

  // Frame collection FSM
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    done    = 1'b0;
    word    = shifted;
`ifdef PARITY_CHECK_EN
    par_calc = 1'b0;
`endif
    if (bit_valid) begin
      unique case (state_q)
        StIdle: begin
          dir_d   = dir;
          shift_d = shifted;
          cnt_d   = CNT_W'(1);
          state_d = StShift;
        end
        StShift: begin
          shift_d = shifted;
          if (cnt_q == LastData) begin
`ifdef PARITY_CHECK_EN
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = StParity;
`else
            cnt_d   = '0;
            state_d = StIdle;
            done    = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`ifdef PARITY_CHECK_EN
        StParity: begin
          // Parity bit is checked but never shifted into the data word.
          word     = shift_q;
          par_calc = (^shift_q) ^ bit_in;
          done     = 1'b1;
          cnt_d    = '0;
          state_d  = StIdle;
        end
`endif
        default: state_d = StIdle;
      endcase
    end
    if (!clear) begin
      // no flush this cycle
    end else begin
      state_d = StIdle;
      shift_d = '0;
      cnt_d   = '0;
      done    = 1'b0;
    end
  end

  // Output buffer and handshake
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
`ifdef PARITY_CHECK_EN
    parity_err_d = parity_err_q;
`endif
    if (clear) begin
      out_valid_d = 1'b0;
      overrun_d   = 1'b0;
`ifdef PARITY_CHECK_EN
      parity_err_d = 1'b0;
`endif
    end else if (done) begin
      if (!out_valid_q || out_ready) begin
        out_d       = word;
        out_valid_d = 1'b1;
`ifdef PARITY_CHECK_EN
        parity_err_d = par_calc;
`endif
      end else begin
        overrun_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      cnt_q       <= '0;
      dir_q       <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef PARITY_CHECK_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
`ifdef PARITY_CHECK_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
  assign busy      = (cnt_q != '0);
  assign bit_count = cnt_q;
`ifdef PARITY_CHECK_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_shift_deserializer.sv
module tb_shift_deserializer;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;
`ifdef PARITY_CHECK_EN
  localparam bit HasParity = 1'b1;
`else
  localparam bit HasParity = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             clear;
  logic             bit_valid;
  logic             bit_in;
  logic             dir;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic [CNT_W-1:0] bit_count;
  logic             overrun;
  logic             parity_err;

  int checks = 0;
  int failures = 0;

  shift_deserializer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .bit_valid  (bit_valid),
    .bit_in     (bit_in),
    .dir        (dir),
    .out        (out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .bit_count  (bit_count),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one bit for one cycle, then idle cycles; returns #1 after the last edge.
  task automatic send_bit(input logic b, input int idle);
    bit_valid = 1'b1;
    bit_in    = b;
    @(posedge clk); #1;
    bit_valid = 1'b0;
    for (int k = 0; k < idle; k++) begin
      @(posedge clk); #1;
    end
  endtask

  // Send a full frame (plus even parity bit when enabled). tog flips dir after the first bit;
  // rdy_last raises out_ready only on the final bit of the frame.
  task automatic send_word(input logic [WIDTH-1:0] w, input logic d, input int idle,
                           input bit tog, input bit rdy_last);
    logic b;
    dir = d;
    for (int i = 0; i < WIDTH; i++) begin
      b = d ? w[i] : w[WIDTH-1-i];
      if (i == WIDTH - 1 && !HasParity && rdy_last) out_ready = 1'b1;
      send_bit(b, idle);
      if (i == 0 && tog) dir = ~d;
    end
    if (HasParity) begin
      if (rdy_last) out_ready = 1'b1;
      send_bit(^w, idle);
    end
    out_ready = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    reset     = 1'b0;
    clear     = 1'b0;
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    dir       = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out", {24'h0, out}, 32'h0);
    chk("reset_out_valid", {31'h0, out_valid}, 32'h0);
    chk("reset_bit_count", {28'h0, bit_count}, 32'h0);
    chk("reset_overrun", {31'h0, overrun}, 32'h0);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_parity_err", {31'h0, parity_err}, 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;

    // MSB first, back-to-back
    send_word(8'hAA, 1'b0, 0, 1'b0, 1'b0);
    chk("msb_out", {24'h0, out}, 32'hAA);
    chk("msb_out_valid", {31'h0, out_valid}, 32'h1);
    chk("msb_bit_count", {28'h0, bit_count}, 32'h0);
    consume();
    chk("msb_consumed", {31'h0, out_valid}, 32'h0);

    // LSB first with 2 idle cycles between bits; peek mid-frame
    dir = 1'b1;
    send_bit(1'b1, 2);
    send_bit(1'b1, 2);
    send_bit(1'b1, 2);
    send_bit(1'b1, 2);
    chk("lsb_busy_mid", {31'h0, busy}, 32'h1);
    chk("lsb_count_mid", {28'h0, bit_count}, 32'h4);
    chk("lsb_no_valid_mid", {31'h0, out_valid}, 32'h0);
    send_bit(1'b0, 2);
    send_bit(1'b0, 2);
    send_bit(1'b0, 2);
    if (HasParity) begin
      send_bit(1'b0, 2);
      send_bit(1'b0, 0);
    end else begin
      send_bit(1'b0, 0);
    end
    chk("lsb_out", {24'h0, out}, 32'h0F);
    chk("lsb_out_valid", {31'h0, out_valid}, 32'h1);
    chk("lsb_busy_end", {31'h0, busy}, 32'h0);
    consume();

    // Backpressure: second word dropped
    send_word(8'h55, 1'b0, 0, 1'b0, 1'b0);
    chk("bp_first", {24'h0, out}, 32'h55);
    send_word(8'h33, 1'b0, 0, 1'b0, 1'b0);
    chk("bp_held_out", {24'h0, out}, 32'h55);
    chk("bp_held_valid", {31'h0, out_valid}, 32'h1);
    chk("bp_overrun", {31'h0, overrun}, 32'h1);
    consume();
    chk("bp_drain_valid", {31'h0, out_valid}, 32'h0);
    chk("bp_overrun_sticky", {31'h0, overrun}, 32'h1);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("clear_overrun", {31'h0, overrun}, 32'h0);
    chk("clear_keeps_out", {24'h0, out}, 32'h55);

    // Same-cycle hand-off
    send_word(8'h12, 1'b0, 0, 1'b0, 1'b0);
    chk("handoff_first", {24'h0, out}, 32'h12);
    send_word(8'h34, 1'b0, 0, 1'b0, 1'b1);
    chk("handoff_out", {24'h0, out}, 32'h34);
    chk("handoff_valid", {31'h0, out_valid}, 32'h1);
    chk("handoff_overrun", {31'h0, overrun}, 32'h0);
    consume();

    // Clear beats completion on the final bit
    dir = 1'b0;
    for (int i = 0; i < WIDTH + (HasParity ? 1 : 0) - 1; i++) send_bit(1'b1, 0);
    clear = 1'b1;
    send_bit(1'b1, 0);
    clear = 1'b0;
    chk("clr_prio_valid", {31'h0, out_valid}, 32'h0);
    chk("clr_prio_count", {28'h0, bit_count}, 32'h0);
    chk("clr_prio_out", {24'h0, out}, 32'h34);

    // Reset mid-frame, then a frame with dir toggled after the first bit
    send_word(8'h34, 1'b0, 0, 1'b0, 1'b0);
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    chk("pre_reset_count", {28'h0, bit_count}, 32'h3);
    reset = 1'b0;
    #1;
    chk("async_reset_out", {24'h0, out}, 32'h0);
    chk("async_reset_valid", {31'h0, out_valid}, 32'h0);
    chk("async_reset_count", {28'h0, bit_count}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    send_word(8'hC3, 1'b0, 0, 1'b1, 1'b0);
    chk("post_reset_out", {24'h0, out}, 32'hC3);
    chk("post_reset_valid", {31'h0, out_valid}, 32'h1);
    consume();

`ifdef PARITY_CHECK_EN
    dir = 1'b0;
    for (int i = 7; i >= 0; i--) send_bit(((8'hAA >> i) & 8'h1) != 0, 0);
    send_bit(1'b0, 0);
    chk("par_ok_out", {24'h0, out}, 32'hAA);
    chk("par_ok_err", {31'h0, parity_err}, 32'h0);
    consume();
    for (int i = 7; i >= 0; i--) send_bit(((8'hAB >> i) & 8'h1) != 0, 0);
    send_bit(1'b0, 0);
    chk("par_bad_out", {24'h0, out}, 32'hAB);
    chk("par_bad_err", {31'h0, parity_err}, 32'h1);
    consume();
`else
    chk("no_parity_err", {31'h0, parity_err}, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
